// File: rtl/dpsram_arb_pkg.sv
// Shared definitions for the two-client SRAM port-A arbiter.
// Holds the default SRAM geometry, the client-ID encoding and the write-enable encoding.
package dpsram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 20;

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_e;

    localparam logic WEN_READ  = 1'b0;
    localparam logic WEN_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a single "last granted" pointer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req[1:0]   - request per client
//   gnt_c[1:0] - combinational one-hot grant (all zero while rst is high)
module rr_arbiter2
    import dpsram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    client_e last_q;

    // Under contention the client that was not granted most recently wins.
    always_comb begin
        gnt_c = 2'b00;
        if (!rst) begin
            if (req[0] && (!req[1] || last_q == CLIENT1)) begin
                gnt_c[0] = 1'b1;
            end else if (req[1]) begin
                gnt_c[1] = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= CLIENT1;
        end else if (gnt_c[0]) begin
            last_q <= CLIENT0;
        end else if (gnt_c[1]) begin
            last_q <= CLIENT1;
        end
    end

endmodule

// File: rtl/dpsram_port_arbiter.sv
// Shares SRAM port A between two requesters: round-robin grant, registered command
// onto the SRAM port, and fixed-latency read-data return to the issuing client.
// Ports:
//   CLK, RST                       - clock, synchronous active-high reset
//   Cx_REQ/WEN/ADDR/DIN            - client x command (held until Cx_GNT)
//   Cx_GNT                         - combinational accept for client x
//   Cx_RVALID/RDATA                - client x read response
//   MEM_BLK_EN/WEN/ADDR/DIN        - registered command to SRAM port A
//   MEM_DOUT                       - SRAM port A read data
module dpsram_port_arbiter
    import dpsram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              C0_REQ,
    input  logic              C0_WEN,
    input  logic [ADDR_W-1:0] C0_ADDR,
    input  logic [DATA_W-1:0] C0_DIN,
    output logic              C0_GNT,
    output logic              C0_RVALID,
    output logic [DATA_W-1:0] C0_RDATA,
    input  logic              C1_REQ,
    input  logic              C1_WEN,
    input  logic [ADDR_W-1:0] C1_ADDR,
    input  logic [DATA_W-1:0] C1_DIN,
    output logic              C1_GNT,
    output logic              C1_RVALID,
    output logic [DATA_W-1:0] C1_RDATA,
    output logic              MEM_BLK_EN,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    logic [1:0]        gnt_c;
    client_e           sel_c;
    logic              sel_wen_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_din_c;

    // Owner of the command currently on the SRAM port.
    client_e           cmd_owner_q;

    // Read tracking pipe; stage 0 is loaded as the SRAM samples the command,
    // so the tail lines up with valid MEM_DOUT.
    logic [RD_LATENCY:0] trk_vld_q;
    logic [RD_LATENCY:0] trk_own_q;

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req   ({C1_REQ, C0_REQ}),
        .gnt_c (gnt_c)
    );

    assign C0_GNT = gnt_c[0];
    assign C1_GNT = gnt_c[1];

    // Winning client's command fields.
    always_comb begin
        sel_c      = gnt_c[1] ? CLIENT1 : CLIENT0;
        sel_wen_c  = C0_WEN;
        sel_addr_c = C0_ADDR;
        sel_din_c  = C0_DIN;
        if (sel_c == CLIENT1) begin
            sel_wen_c  = C1_WEN;
            sel_addr_c = C1_ADDR;
            sel_din_c  = C1_DIN;
        end
    end

    // Command register and read tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_BLK_EN  <= 1'b0;
            MEM_WEN     <= WEN_READ;
            MEM_ADDR    <= '0;
            MEM_DIN     <= '0;
            cmd_owner_q <= CLIENT0;
            trk_vld_q   <= '0;
            trk_own_q   <= '0;
        end else begin
            if (gnt_c != 2'b00) begin
                MEM_BLK_EN  <= 1'b1;
                MEM_WEN     <= sel_wen_c;
                MEM_ADDR    <= sel_addr_c;
                MEM_DIN     <= sel_din_c;
                cmd_owner_q <= sel_c;
            end else begin
                MEM_BLK_EN <= 1'b0;
                MEM_WEN    <= WEN_READ;
            end
            trk_vld_q <= {trk_vld_q[RD_LATENCY-1:0], MEM_BLK_EN && (MEM_WEN == WEN_READ)};
            trk_own_q <= {trk_own_q[RD_LATENCY-1:0], cmd_owner_q == CLIENT1};
        end
    end

    assign C0_RVALID = trk_vld_q[RD_LATENCY] && (trk_own_q[RD_LATENCY] == CLIENT0);
    assign C1_RVALID = trk_vld_q[RD_LATENCY] && (trk_own_q[RD_LATENCY] == CLIENT1);
    assign C0_RDATA  = MEM_DOUT;
    assign C1_RDATA  = MEM_DOUT;

endmodule

// File: tb/tb_dpsram_port_arbiter.sv
// Self-checking bench for dpsram_port_arbiter with a behavioural SRAM and scoreboard.
module tb_dpsram_port_arbiter;
    import dpsram_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [5:0]  addr [2];
    logic [19:0] din  [2];

    logic        C0_GNT, C1_GNT, C0_RVALID, C1_RVALID;
    logic [19:0] C0_RDATA, C1_RDATA;
    logic        MEM_BLK_EN, MEM_WEN;
    logic [5:0]  MEM_ADDR;
    logic [19:0] MEM_DIN;
    logic [19:0] MEM_DOUT;

    dpsram_port_arbiter dut (
        .CLK(clk), .RST(rst),
        .C0_REQ(req[0]), .C0_WEN(wen[0]), .C0_ADDR(addr[0]), .C0_DIN(din[0]),
        .C0_GNT(C0_GNT), .C0_RVALID(C0_RVALID), .C0_RDATA(C0_RDATA),
        .C1_REQ(req[1]), .C1_WEN(wen[1]), .C1_ADDR(addr[1]), .C1_DIN(din[1]),
        .C1_GNT(C1_GNT), .C1_RVALID(C1_RVALID), .C1_RDATA(C1_RDATA),
        .MEM_BLK_EN(MEM_BLK_EN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM port A: samples a command on an edge, data appears one edge later.
    logic        mem_clr;
    logic [19:0] sram [64];
    logic [19:0] sram_pipe;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) sram[i] <= 20'h0;
        end else if (MEM_BLK_EN) begin
            if (MEM_WEN) sram[MEM_ADDR] <= MEM_DIN;
            else         sram_pipe <= sram[MEM_ADDR];
        end
        MEM_DOUT <= sram_pipe;
    end

    // Reference model state.
    typedef struct {
        int          own;
        logic [19:0] data;
        int          due;
    } resp_t;

    resp_t       q[$];
    logic [19:0] mm [64];
    int          last_m;
    int          cyc;
    logic [1:0]  gnt_m;
    logic        exp_blk, exp_wen;
    logic [5:0]  exp_addr;
    logic [19:0] exp_din;
    int          errors;
    int          checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        bit eg0, eg1, ev0, ev1;
        int c;
        @(negedge clk);
        eg0 = !rst && req[0] && (!req[1] || last_m == 1);
        eg1 = !rst && req[1] && !eg0;
        check("c0_gnt", 32'(C0_GNT), 32'(eg0));
        check("c1_gnt", 32'(C1_GNT), 32'(eg1));
        ev0 = (q.size() > 0) && (q[0].due == cyc) && (q[0].own == 0);
        ev1 = (q.size() > 0) && (q[0].due == cyc) && (q[0].own == 1);
        check("c0_rvalid", 32'(C0_RVALID), 32'(ev0));
        check("c1_rvalid", 32'(C1_RVALID), 32'(ev1));
        if (ev0) check("c0_rdata", 32'(C0_RDATA), 32'(q[0].data));
        if (ev1) check("c1_rdata", 32'(C1_RDATA), 32'(q[0].data));
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        check("mem_blk_en", 32'(MEM_BLK_EN), 32'(exp_blk));
        check("mem_wen", 32'(MEM_WEN), 32'(exp_wen));
        check("mem_addr", 32'(MEM_ADDR), 32'(exp_addr));
        check("mem_din", 32'(MEM_DIN), 32'(exp_din));
        @(posedge clk);
        cyc++;
        gnt_m = {eg1, eg0};
        if (rst) begin
            q.delete();
            last_m   = 1;
            exp_blk  = 1'b0;
            exp_wen  = 1'b0;
            exp_addr = 6'h0;
            exp_din  = 20'h0;
        end else if (eg0 || eg1) begin
            c        = eg1 ? 1 : 0;
            last_m   = c;
            exp_blk  = 1'b1;
            exp_wen  = wen[c];
            exp_addr = addr[c];
            exp_din  = din[c];
            if (wen[c]) mm[addr[c]] = din[c];
            else        q.push_back('{own: c, data: mm[addr[c]], due: cyc + 2});
        end else begin
            exp_blk = 1'b0;
            exp_wen = 1'b0;
        end
        #1;
    endtask

    task automatic cmd(input int c, input logic w, input logic [5:0] a, input logic [19:0] d);
        wen[c]  = w;
        addr[c] = a;
        din[c]  = d;
        req[c]  = 1'b1;
        cycle();
        req[c]  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        mem_clr = 1'b1;
        req    = 2'b00;
        wen    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 6'h0;
            din[i]  = 20'h0;
        end
        for (int i = 0; i < 64; i++) mm[i] = 20'h0;
        last_m = 1; exp_blk = 1'b0; exp_wen = 1'b0; exp_addr = 6'h0; exp_din = 20'h0;
        gnt_m = 2'b00;
        @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Reset held with both clients requesting: nothing granted.
        req = 2'b11;
        addr[0] = 6'd1;
        addr[1] = 6'd2;
        idle(3);
        rst = 1'b0;
        cycle();
        check("first_gnt_c0", 32'(gnt_m), 32'(2'b01));
        req[0] = 1'b0;
        cycle();
        req = 2'b00;
        idle(3);

        // Single client write then read.
        cmd(0, WEN_WRITE, 6'd5, 20'h12345);
        cmd(0, 1'b0, 6'd5, 20'h0);
        idle(3);

        // Continuous contention: grants alternate, responses in order.
        wen = 2'b00;
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cycle();
            for (int c = 0; c < 2; c++)
                if (gnt_m[c]) addr[c] = 6'($urandom_range(0, 7));
        end
        req = 2'b00;
        idle(3);

        // Address extremes and data extremes.
        cmd(1, WEN_WRITE, 6'd63, 20'hFFFFF);
        cmd(1, WEN_WRITE, 6'd0, 20'h00001);
        cmd(1, 1'b0, 6'd63, 20'h0);
        cmd(1, 1'b0, 6'd0, 20'h0);
        idle(3);

        // Read-after-write across clients on consecutive grants.
        cmd(0, WEN_WRITE, 6'd10, 20'hABCDE);
        cmd(1, 1'b0, 6'd10, 20'h0);
        idle(3);

        // Reset with two reads in flight: both discarded.
        cmd(1, 1'b0, 6'd63, 20'h0);
        cmd(0, 1'b0, 6'd0, 20'h0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        cmd(0, 1'b0, 6'd63, 20'h0);
        idle(3);

        // Random traffic with hold-until-granted and occasional request drops.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!req[c] && $urandom_range(0, 2) != 0) begin
                    req[c]  = 1'b1;
                    wen[c]  = 1'($urandom_range(0, 1));
                    addr[c] = 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h38 : 6'h00);
                    din[c]  = 20'($urandom);
                end
            end
            cycle();
            for (int c = 0; c < 2; c++) begin
                if (gnt_m[c]) req[c] = 1'b0;
                else if (req[c] && $urandom_range(0, 9) == 0) req[c] = 1'b0;
            end
        end
        req = 2'b00;
        idle(4);
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
